dual_systolic_array_4x4: RTL and testbench

Computes two signed 4x4 integer matrix products in parallel, C1 = A×B1 and C2 = A×B2, using two output-stationary 4x4 systolic processing-element (PE) arrays. Both arrays share the same A operand. The block is the matrix-multiply engine of the self-attention datapath, where A is the input and B1/B2 are two weight matrices. Operands are 8-bit signed, results are 16-bit signed, and a `done` flag marks when all 32 results are valid.

---
 rtl/dual_systolic_array_4x4_if.sv | 63 ++++++
 rtl/dual_systolic_array_4x4.sv | 111 +++++++++++
 tb/tb_dual_systolic_array_4x4.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dual_systolic_array_4x4_if.sv
// dual_systolic_array_4x4_if: operand, flush, result and status bundle for dual_systolic_array_4x4
//   _flush_acc           : active-low synchronous flush (master -> slave)
//   aRC, b1_RC, b2_RC    : signed width-bit operands, row R column C (master -> slave)
//   result1_k, result2_k : signed 2*width-bit products C1/C2[k/4][k%4] (slave -> master)
//   done                 : all 32 results final (slave -> master)
interface dual_systolic_array_4x4_if #(
    parameter int width = 8
);
    logic                      _flush_acc;
    logic signed [width-1:0]   a00, a01, a02, a03, a10, a11, a12, a13,
                               a20, a21, a22, a23, a30, a31, a32, a33;
    logic signed [width-1:0]   b1_00, b1_10, b1_20, b1_30, b1_01, b1_11, b1_21, b1_31,
                               b1_02, b1_12, b1_22, b1_32, b1_03, b1_13, b1_23, b1_33;
    logic signed [width-1:0]   b2_00, b2_10, b2_20, b2_30, b2_01, b2_11, b2_21, b2_31,
                               b2_02, b2_12, b2_22, b2_32, b2_03, b2_13, b2_23, b2_33;
    logic signed [2*width-1:0] result1_0, result1_1, result1_2, result1_3,
                               result1_4, result1_5, result1_6, result1_7,
                               result1_8, result1_9, result1_10, result1_11,
                               result1_12, result1_13, result1_14, result1_15;
    logic signed [2*width-1:0] result2_0, result2_1, result2_2, result2_3,
                               result2_4, result2_5, result2_6, result2_7,
                               result2_8, result2_9, result2_10, result2_11,
                               result2_12, result2_13, result2_14, result2_15;
    logic                      done;

    modport master (
        output _flush_acc,
        output a00, a01, a02, a03, a10, a11, a12, a13,
               a20, a21, a22, a23, a30, a31, a32, a33,
        output b1_00, b1_10, b1_20, b1_30, b1_01, b1_11, b1_21, b1_31,
               b1_02, b1_12, b1_22, b1_32, b1_03, b1_13, b1_23, b1_33,
        output b2_00, b2_10, b2_20, b2_30, b2_01, b2_11, b2_21, b2_31,
               b2_02, b2_12, b2_22, b2_32, b2_03, b2_13, b2_23, b2_33,
        input  result1_0, result1_1, result1_2, result1_3,
               result1_4, result1_5, result1_6, result1_7,
               result1_8, result1_9, result1_10, result1_11,
               result1_12, result1_13, result1_14, result1_15,
        input  result2_0, result2_1, result2_2, result2_3,
               result2_4, result2_5, result2_6, result2_7,
               result2_8, result2_9, result2_10, result2_11,
               result2_12, result2_13, result2_14, result2_15,
        input  done
    );

    modport slave (
        input  _flush_acc,
        input  a00, a01, a02, a03, a10, a11, a12, a13,
               a20, a21, a22, a23, a30, a31, a32, a33,
        input  b1_00, b1_10, b1_20, b1_30, b1_01, b1_11, b1_21, b1_31,
               b1_02, b1_12, b1_22, b1_32, b1_03, b1_13, b1_23, b1_33,
        input  b2_00, b2_10, b2_20, b2_30, b2_01, b2_11, b2_21, b2_31,
               b2_02, b2_12, b2_22, b2_32, b2_03, b2_13, b2_23, b2_33,
        output result1_0, result1_1, result1_2, result1_3,
               result1_4, result1_5, result1_6, result1_7,
               result1_8, result1_9, result1_10, result1_11,
               result1_12, result1_13, result1_14, result1_15,
        output result2_0, result2_1, result2_2, result2_3,
               result2_4, result2_5, result2_6, result2_7,
               result2_8, result2_9, result2_10, result2_11,
               result2_12, result2_13, result2_14, result2_15,
        output done
    );
endinterface

// File: rtl/dual_systolic_array_4x4.sv
// dual_systolic_array_4x4: two output-stationary 4x4 systolic arrays computing C1 = A*B1 and C2 = A*B2
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of dual_systolic_array_4x4_if (operands, flush, results, done)
module dual_systolic_array_4x4 #(
    parameter int width = 8
) (
    input logic                      clk,
    input logic                      reset,
    dual_systolic_array_4x4_if.slave bus
);
    logic signed [width-1:0]   a_m   [4][4];
    logic signed [width-1:0]   b_m   [2][4][4];
    logic signed [width-1:0]   a_inj [4];
    logic signed [width-1:0]   b_inj [2][4];
    logic signed [width-1:0]   a_q   [2][4][4];
    logic signed [width-1:0]   a_d   [2][4][4];
    logic signed [width-1:0]   b_q   [2][4][4];
    logic signed [width-1:0]   b_d   [2][4][4];
    logic signed [2*width-1:0] acc_q [2][4][4];
    logic signed [2*width-1:0] acc_d [2][4][4];
    logic [3:0]                cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      flush;

    assign flush = !bus._flush_acc;

    assign a_m[0][0] = bus.a00; assign a_m[0][1] = bus.a01; assign a_m[0][2] = bus.a02; assign a_m[0][3] = bus.a03;
    assign a_m[1][0] = bus.a10; assign a_m[1][1] = bus.a11; assign a_m[1][2] = bus.a12; assign a_m[1][3] = bus.a13;
    assign a_m[2][0] = bus.a20; assign a_m[2][1] = bus.a21; assign a_m[2][2] = bus.a22; assign a_m[2][3] = bus.a23;
    assign a_m[3][0] = bus.a30; assign a_m[3][1] = bus.a31; assign a_m[3][2] = bus.a32; assign a_m[3][3] = bus.a33;

    assign b_m[0][0][0] = bus.b1_00; assign b_m[0][1][0] = bus.b1_10; assign b_m[0][2][0] = bus.b1_20; assign b_m[0][3][0] = bus.b1_30;
    assign b_m[0][0][1] = bus.b1_01; assign b_m[0][1][1] = bus.b1_11; assign b_m[0][2][1] = bus.b1_21; assign b_m[0][3][1] = bus.b1_31;
    assign b_m[0][0][2] = bus.b1_02; assign b_m[0][1][2] = bus.b1_12; assign b_m[0][2][2] = bus.b1_22; assign b_m[0][3][2] = bus.b1_32;
    assign b_m[0][0][3] = bus.b1_03; assign b_m[0][1][3] = bus.b1_13; assign b_m[0][2][3] = bus.b1_23; assign b_m[0][3][3] = bus.b1_33;

    assign b_m[1][0][0] = bus.b2_00; assign b_m[1][1][0] = bus.b2_10; assign b_m[1][2][0] = bus.b2_20; assign b_m[1][3][0] = bus.b2_30;
    assign b_m[1][0][1] = bus.b2_01; assign b_m[1][1][1] = bus.b2_11; assign b_m[1][2][1] = bus.b2_21; assign b_m[1][3][1] = bus.b2_31;
    assign b_m[1][0][2] = bus.b2_02; assign b_m[1][1][2] = bus.b2_12; assign b_m[1][2][2] = bus.b2_22; assign b_m[1][3][2] = bus.b2_32;
    assign b_m[1][0][3] = bus.b2_03; assign b_m[1][1][3] = bus.b2_13; assign b_m[1][2][3] = bus.b2_23; assign b_m[1][3][3] = bus.b2_33;

    // Skewed injection: at count t, row i takes A[i][t-i] and column j takes B[t-j][j]; zero outside the 4-wide window.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_inj[i]    = '0;
            b_inj[0][i] = '0;
            b_inj[1][i] = '0;
            for (int k = 0; k < 4; k++) begin
                if (int'(cnt_q) == i + k) begin
                    a_inj[i]    = a_m[i][k];
                    b_inj[0][i] = b_m[0][k][i];
                    b_inj[1][i] = b_m[1][k][i];
                end
            end
        end
    end

    // Each PE consumes the operand its left/upper neighbour registered last cycle (or the injected one on the
    // boundary) and registers it for the next neighbour. The (x+3)%4 index is only selected for x>0 and just
    // keeps the neighbour index in range for the boundary PEs.
    always_comb begin
        cnt_d  = flush ? 4'd0 : (cnt_q == 4'd10) ? cnt_q : cnt_q + 4'd1;
        done_d = !flush && (done_q || cnt_q == 4'd9);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_d[g][i][j]   = flush ? '0 : (j == 0) ? a_inj[i] : a_q[g][i][(j + 3) % 4];
                    b_d[g][i][j]   = flush ? '0 : (i == 0) ? b_inj[g][j] : b_q[g][(i + 3) % 4][j];
                    acc_d[g][i][j] = flush ? '0 : acc_q[g][i][j] + (2*width)'(a_d[g][i][j]) * (2*width)'(b_d[g][i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            acc_q  <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

    assign bus.done = done_q;

    assign bus.result1_0  = acc_q[0][0][0]; assign bus.result1_1  = acc_q[0][0][1];
    assign bus.result1_2  = acc_q[0][0][2]; assign bus.result1_3  = acc_q[0][0][3];
    assign bus.result1_4  = acc_q[0][1][0]; assign bus.result1_5  = acc_q[0][1][1];
    assign bus.result1_6  = acc_q[0][1][2]; assign bus.result1_7  = acc_q[0][1][3];
    assign bus.result1_8  = acc_q[0][2][0]; assign bus.result1_9  = acc_q[0][2][1];
    assign bus.result1_10 = acc_q[0][2][2]; assign bus.result1_11 = acc_q[0][2][3];
    assign bus.result1_12 = acc_q[0][3][0]; assign bus.result1_13 = acc_q[0][3][1];
    assign bus.result1_14 = acc_q[0][3][2]; assign bus.result1_15 = acc_q[0][3][3];

    assign bus.result2_0  = acc_q[1][0][0]; assign bus.result2_1  = acc_q[1][0][1];
    assign bus.result2_2  = acc_q[1][0][2]; assign bus.result2_3  = acc_q[1][0][3];
    assign bus.result2_4  = acc_q[1][1][0]; assign bus.result2_5  = acc_q[1][1][1];
    assign bus.result2_6  = acc_q[1][1][2]; assign bus.result2_7  = acc_q[1][1][3];
    assign bus.result2_8  = acc_q[1][2][0]; assign bus.result2_9  = acc_q[1][2][1];
    assign bus.result2_10 = acc_q[1][2][2]; assign bus.result2_11 = acc_q[1][2][3];
    assign bus.result2_12 = acc_q[1][3][0]; assign bus.result2_13 = acc_q[1][3][1];
    assign bus.result2_14 = acc_q[1][3][2]; assign bus.result2_15 = acc_q[1][3][3];
endmodule

// File: tb/tb_dual_systolic_array_4x4.sv
// tb_dual_systolic_array_4x4: directed and randomized checks of dual_systolic_array_4x4 against a matrix-product model
module tb_dual_systolic_array_4x4;
    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              flush_n = 1'b1;
    logic signed [7:0] A  [4][4];
    logic signed [7:0] B1 [4][4];
    logic signed [7:0] B2 [4][4];
    logic [15:0]       r1 [16];
    logic [15:0]       r2 [16];
    logic [15:0]       e1 [16];
    logic [15:0]       e2 [16];
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    dual_systolic_array_4x4_if #(.width(8)) bus ();
    dual_systolic_array_4x4 #(.width(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus._flush_acc = flush_n;

    assign bus.a00 = A[0][0]; assign bus.a01 = A[0][1]; assign bus.a02 = A[0][2]; assign bus.a03 = A[0][3];
    assign bus.a10 = A[1][0]; assign bus.a11 = A[1][1]; assign bus.a12 = A[1][2]; assign bus.a13 = A[1][3];
    assign bus.a20 = A[2][0]; assign bus.a21 = A[2][1]; assign bus.a22 = A[2][2]; assign bus.a23 = A[2][3];
    assign bus.a30 = A[3][0]; assign bus.a31 = A[3][1]; assign bus.a32 = A[3][2]; assign bus.a33 = A[3][3];

    assign bus.b1_00 = B1[0][0]; assign bus.b1_10 = B1[1][0]; assign bus.b1_20 = B1[2][0]; assign bus.b1_30 = B1[3][0];
    assign bus.b1_01 = B1[0][1]; assign bus.b1_11 = B1[1][1]; assign bus.b1_21 = B1[2][1]; assign bus.b1_31 = B1[3][1];
    assign bus.b1_02 = B1[0][2]; assign bus.b1_12 = B1[1][2]; assign bus.b1_22 = B1[2][2]; assign bus.b1_32 = B1[3][2];
    assign bus.b1_03 = B1[0][3]; assign bus.b1_13 = B1[1][3]; assign bus.b1_23 = B1[2][3]; assign bus.b1_33 = B1[3][3];

    assign bus.b2_00 = B2[0][0]; assign bus.b2_10 = B2[1][0]; assign bus.b2_20 = B2[2][0]; assign bus.b2_30 = B2[3][0];
    assign bus.b2_01 = B2[0][1]; assign bus.b2_11 = B2[1][1]; assign bus.b2_21 = B2[2][1]; assign bus.b2_31 = B2[3][1];
    assign bus.b2_02 = B2[0][2]; assign bus.b2_12 = B2[1][2]; assign bus.b2_22 = B2[2][2]; assign bus.b2_32 = B2[3][2];
    assign bus.b2_03 = B2[0][3]; assign bus.b2_13 = B2[1][3]; assign bus.b2_23 = B2[2][3]; assign bus.b2_33 = B2[3][3];

    assign r1[0]  = bus.result1_0;  assign r1[1]  = bus.result1_1;  assign r1[2]  = bus.result1_2;  assign r1[3]  = bus.result1_3;
    assign r1[4]  = bus.result1_4;  assign r1[5]  = bus.result1_5;  assign r1[6]  = bus.result1_6;  assign r1[7]  = bus.result1_7;
    assign r1[8]  = bus.result1_8;  assign r1[9]  = bus.result1_9;  assign r1[10] = bus.result1_10; assign r1[11] = bus.result1_11;
    assign r1[12] = bus.result1_12; assign r1[13] = bus.result1_13; assign r1[14] = bus.result1_14; assign r1[15] = bus.result1_15;

    assign r2[0]  = bus.result2_0;  assign r2[1]  = bus.result2_1;  assign r2[2]  = bus.result2_2;  assign r2[3]  = bus.result2_3;
    assign r2[4]  = bus.result2_4;  assign r2[5]  = bus.result2_5;  assign r2[6]  = bus.result2_6;  assign r2[7]  = bus.result2_7;
    assign r2[8]  = bus.result2_8;  assign r2[9]  = bus.result2_9;  assign r2[10] = bus.result2_10; assign r2[11] = bus.result2_11;
    assign r2[12] = bus.result2_12; assign r2[13] = bus.result2_13; assign r2[14] = bus.result2_14; assign r2[15] = bus.result2_15;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed matrix product, truncated to 16 bits.
    task automatic model();
        int s1, s2;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s1 = 0;
                s2 = 0;
                for (int k = 0; k < 4; k++) begin
                    s1 += int'(A[i][k]) * int'(B1[k][j]);
                    s2 += int'(A[i][k]) * int'(B2[k][j]);
                end
                e1[i*4+j] = s1[15:0];
                e2[i*4+j] = s2[15:0];
            end
        end
    endtask

    task automatic rnd_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j]  = 8'($urandom);
                B1[i][j] = 8'($urandom);
                B2[i][j] = 8'($urandom);
            end
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s done", tag), 16'(bus.done), 16'd0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s r1[%0d]", tag, k), r1[k], 16'd0);
            chk($sformatf("%s r2[%0d]", tag, k), r2[k], 16'd0);
        end
    endtask

    task automatic chk_final(input string tag);
        chk($sformatf("%s done", tag), 16'(bus.done), 16'd1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s r1[%0d]", tag, k), r1[k], e1[k]);
            chk($sformatf("%s r2[%0d]", tag, k), r2[k], e2[k]);
        end
    endtask

    // Called at a falling edge: one flush edge, check everything cleared, then release.
    task automatic restart(input string tag);
        flush_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero({tag, " flush"});
        flush_n = 1'b1;
    endtask

    // Ten edges from the start; PE(i,j) must be final from edge i+j+4, done exactly from edge 10.
    task automatic run(input string tag);
        model();
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s done e%0d", tag, e), 16'(bus.done), (e == 10) ? 16'd1 : 16'd0);
            for (int k = 0; k < 16; k++)
                if (k / 4 + k % 4 + 4 <= e) begin
                    chk($sformatf("%s r1[%0d] e%0d", tag, k, e), r1[k], e1[k]);
                    chk($sformatf("%s r2[%0d] e%0d", tag, k, e), r2[k], e2[k]);
                end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j]  = (i == j) ? 8'sd1 : 8'sd0;
                B1[i][j] = 8'(4 * i + j + 1);
                B2[i][j] = (i == j) ? 8'sd2 : 8'sd0;
            end
        #2 reset = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        run("ident");
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ident const r1[%0d]", k), r1[k], 16'(k + 1));
            chk($sformatf("ident const r2[%0d]", k), r2[k], (k / 4 == k % 4) ? 16'd2 : 16'd0);
        end
        rnd_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j]  = 8'h80;
                B1[i][j] = 8'h80;
            end
        restart("wrapneg");
        run("wrapneg");
        for (int k = 0; k < 16; k++) chk($sformatf("wrapneg const r1[%0d]", k), r1[k], 16'h0000);
        rnd_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j]  = 8'h7F;
                B2[i][j] = 8'h7F;
            end
        restart("wrappos");
        run("wrappos");
        for (int k = 0; k < 16; k++) chk($sformatf("wrappos const r2[%0d]", k), r2[k], 16'hFC04);
        for (int n = 0; n < 3; n++) begin
            rnd_all();
            restart($sformatf("rand%0d", n));
            run($sformatf("rand%0d", n));
            repeat (20) @(negedge clk);
            chk_final($sformatf("rand%0d hold", n));
        end
        rnd_all();
        restart("flushmid pre");
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rnd_all();
        restart("flushmid");
        run("flushmid");
        rnd_all();
        restart("rstmid pre");
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 chk_zero("rstmid async");
        @(negedge clk);
        reset = 1'b1;
        run("rstmid");
        #2 reset = 1'b0;
        #1 chk_zero("rstdone async");
        @(negedge clk);
        reset = 1'b1;
        run("rstdone");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
